// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PC redirect controller: FSM states, source codes
// and redirect priority ranking. PC_CTRL_IRQ_EN enables interrupt redirects.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef logic [2:0] src_t;

    localparam src_t SRC_NONE   = 3'd0;
    localparam src_t SRC_BRANCH = 3'd1;
    localparam src_t SRC_JUMP   = 3'd2;
    localparam src_t SRC_IRQ    = 3'd3;
    localparam src_t SRC_MRET   = 3'd4;

`ifdef PC_CTRL_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    function automatic logic [2:0] prio_rank(input src_t src);
        logic [2:0] r;
        r = 3'd0;
        case (src)
            SRC_BRANCH: r = 3'd1;
            SRC_JUMP:   r = 3'd2;
            SRC_IRQ:    r = 3'd3;
            SRC_MRET:   r = 3'd4;
            default:    r = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_redirect_prio.sv
// Combinational winner select among redirect requests.
// Interrupts are only visible when PC_CTRL_IRQ_EN is defined.
module pc_redirect_prio
    import pc_ctrl_pkg::*;
(
    input  logic        mret_req_i,
    input  logic [31:0] mepc_i,
    input  logic        irq_req_i,
    input  logic [31:0] interrupt_vector_i,
    input  logic        jump_req_i,
    input  logic        branch_req_i,
    input  logic [31:0] target_pc_i,
    output src_t        win_src_o,
    output logic [31:0] win_pc_o
);

    logic irq_req;

`ifdef PC_CTRL_IRQ_EN
    assign irq_req = irq_req_i;
`else
    logic unused_irq;
    assign irq_req    = 1'b0;
    assign unused_irq = ^{irq_req_i, interrupt_vector_i};
`endif

    always_comb begin
        win_src_o = SRC_NONE;
        win_pc_o  = '0;
        priority case (1'b1)
            mret_req_i: begin
                win_src_o = SRC_MRET;
                win_pc_o  = mepc_i;
            end
            irq_req: begin
                win_src_o = SRC_IRQ;
                win_pc_o  = interrupt_vector_i;
            end
            jump_req_i: begin
                win_src_o = SRC_JUMP;
                win_pc_o  = target_pc_i;
            end
            branch_req_i: begin
                win_src_o = SRC_BRANCH;
                win_pc_o  = target_pc_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: latch, hold until fetch accepts, then flush.
// Build with PC_CTRL_IRQ_EN to arbitrate interrupt redirects.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [2:0]  RESET_SRC    = 3'd0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_design,
    input  logic        stage_IF_ready,
    input  logic        jump_req_i,
    input  logic        branch_req_i,
    input  logic [31:0] target_pc_i,
    input  logic        mret_req_i,
    input  logic [31:0] mepc_i,
    input  logic        irq_req_i,
    input  logic [31:0] interrupt_vector_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic [2:0]  redirect_src_o,
    output logic        flush_o,
    output logic        irq_ack_o,
    output logic        mret_ack_o,
    output logic        misalign_o,
    output logic        busy_o
);

    localparam logic [2:0] FC_LD = 3'(FLUSH_CYCLES);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    src_t        src_q, src_d;
    logic        iack_q, iack_d;
    logic        mack_q, mack_d;
    logic        mis_q, mis_d;
    logic        xfer;
    src_t        win_src;
    logic [31:0] win_pc;

    pc_redirect_prio u_prio (
        .mret_req_i         (mret_req_i),
        .mepc_i             (mepc_i),
        .irq_req_i          (irq_req_i),
        .interrupt_vector_i (interrupt_vector_i),
        .jump_req_i         (jump_req_i),
        .branch_req_i       (branch_req_i),
        .target_pc_i        (target_pc_i),
        .win_src_o          (win_src),
        .win_pc_o           (win_pc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        src_d   = src_q;
        iack_d  = 1'b0;
        mack_d  = 1'b0;
        mis_d   = 1'b0;
        xfer    = 1'b0;
        if (enable_design) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (win_src != SRC_NONE) begin
                        pc_d    = {win_pc[31:2], 2'b00};
                        src_d   = win_src;
                        mis_d   = |win_pc[1:0];
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Acceptance beats a same-cycle preemption.
                    if (stage_IF_ready) begin
                        xfer   = 1'b1;
                        iack_d = IRQ_ON && (src_q == SRC_IRQ);
                        mack_d = (src_q == SRC_MRET);
                        if (FC_LD == 3'd0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_FLUSH;
                            cnt_d   = FC_LD;
                        end
                    end else if (prio_rank(win_src) > prio_rank(src_q)) begin
                        pc_d  = {win_pc[31:2], 2'b00};
                        src_d = win_src;
                        mis_d = |win_pc[1:0];
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            pc_q    <= '0;
            src_q   <= RESET_SRC;
            iack_q  <= 1'b0;
            mack_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            src_q   <= src_d;
            iack_q  <= iack_d;
            mack_q  <= mack_d;
            mis_q   <= mis_d;
        end
    end

    assign redirect_valid_o = (state_q == ST_HOLD);
    assign redirect_pc_o    = pc_q;
    assign redirect_src_o   = src_q;
    assign flush_o          = xfer || (state_q == ST_FLUSH);
    assign irq_ack_o        = iack_q;
    assign mret_ack_o       = mack_q;
    assign misalign_o       = mis_q;
    assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl (default FLUSH_CYCLES=2).
// Interrupt expectations follow PC_CTRL_IRQ_EN.
module tb_pc_redirect_ctrl;

`ifdef PC_CTRL_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        enable_design;
    logic        stage_IF_ready;
    logic        jump_req_i;
    logic        branch_req_i;
    logic [31:0] target_pc_i;
    logic        mret_req_i;
    logic [31:0] mepc_i;
    logic        irq_req_i;
    logic [31:0] interrupt_vector_i;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [2:0]  redirect_src_o;
    logic        flush_o;
    logic        irq_ack_o;
    logic        mret_ack_o;
    logic        misalign_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    pc_redirect_ctrl dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .enable_design      (enable_design),
        .stage_IF_ready     (stage_IF_ready),
        .jump_req_i         (jump_req_i),
        .branch_req_i       (branch_req_i),
        .target_pc_i        (target_pc_i),
        .mret_req_i         (mret_req_i),
        .mepc_i             (mepc_i),
        .irq_req_i          (irq_req_i),
        .interrupt_vector_i (interrupt_vector_i),
        .redirect_valid_o   (redirect_valid_o),
        .redirect_pc_o      (redirect_pc_o),
        .redirect_src_o     (redirect_src_o),
        .flush_o            (flush_o),
        .irq_ack_o          (irq_ack_o),
        .mret_ack_o         (mret_ack_o),
        .misalign_o         (misalign_o),
        .busy_o             (busy_o)
    );

    // {valid, pc, src, flush, irq_ack, mret_ack, misalign, busy}
    wire [40:0] obs = {redirect_valid_o, redirect_pc_o, redirect_src_o,
                       flush_o, irq_ack_o, mret_ack_o, misalign_o, busy_o};

    function automatic logic [40:0] ex(input bit v, input logic [31:0] pc,
                                       input logic [2:0] src, input bit fl,
                                       input bit ia, input bit ma,
                                       input bit mi, input bit bu);
        return {v, pc, src, fl, ia, ma, mi, bu};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        stage_IF_ready     = 1'b0;
        jump_req_i         = 1'b0;
        branch_req_i       = 1'b0;
        target_pc_i        = '0;
        mret_req_i         = 1'b0;
        mepc_i             = '0;
        irq_req_i          = 1'b0;
        interrupt_vector_i = '0;
    endtask

    task automatic test_reset();
        logic [40:0] e;
        reset_i       = 1'b0;
        enable_design = 1'b1;
        idle_inputs();
        tick();
        tick();
        e = ex(0, 32'h0, 3'd0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs, e);
        end
        reset_i = 1'b1;
        tick();
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs, e);
        end
    endtask

    task automatic test_jump_flush();
        logic [40:0] e;
        jump_req_i     = 1'b1;
        target_pc_i    = 32'h0000_0100;
        stage_IF_ready = 1'b1;
        tick();
        jump_req_i = 1'b0;
        e = ex(1, 32'h100, 3'd2, 1, 0, 0, 0, 1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s1_hold got=%h exp=%h", obs, e);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            e = ex(0, 32'h100, 3'd2, 1, 0, 0, 0, 1);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL s1_flush%0d got=%h exp=%h", i, obs, e);
            end
        end
        tick();
        e = ex(0, 32'h100, 3'd2, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s1_idle got=%h exp=%h", obs, e);
        end
        stage_IF_ready = 1'b0;
    endtask

    task automatic test_preempt_mret();
        logic [40:0] e;
        branch_req_i = 1'b1;
        target_pc_i  = 32'h0000_0040;
        tick();
        branch_req_i = 1'b0;
        e = ex(1, 32'h40, 3'd1, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s2_branch got=%h exp=%h", obs, e);
        end
        mret_req_i = 1'b1;
        mepc_i     = 32'h0000_0200;
        tick();
        mret_req_i = 1'b0;
        e = ex(1, 32'h200, 3'd4, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s2_preempt got=%h exp=%h", obs, e);
        end
        jump_req_i  = 1'b1;
        target_pc_i = 32'h0000_0300;
        tick();
        jump_req_i = 1'b0;
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s2_lower_dropped got=%h exp=%h", obs, e);
        end
        stage_IF_ready = 1'b1;
        #1;
        e = ex(1, 32'h200, 3'd4, 1, 0, 0, 0, 1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s2_xfer got=%h exp=%h", obs, e);
        end
        tick();
        stage_IF_ready = 1'b0;
        e = ex(0, 32'h200, 3'd4, 1, 0, 1, 0, 1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s2_mret_ack got=%h exp=%h", obs, e);
        end
        tick();
        e = ex(0, 32'h200, 3'd4, 1, 0, 0, 0, 1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s2_ack_once got=%h exp=%h", obs, e);
        end
        tick();
    endtask

    task automatic test_irq_after_flush();
        logic [40:0] e;
        jump_req_i     = 1'b1;
        target_pc_i    = 32'h0000_0010;
        stage_IF_ready = 1'b1;
        tick();
        jump_req_i = 1'b0;
        tick();
        irq_req_i          = 1'b1;
        interrupt_vector_i = 32'h0000_0080;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (redirect_valid_o !== 1'b0 || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL s3_flush%0d valid=%b busy=%b exp valid=0 busy=1",
                         i, redirect_valid_o, busy_o);
            end
            tick();
        end
        e = ex(0, 32'h10, 3'd2, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s3_idle got=%h exp=%h", obs, e);
        end
        tick();
        e = IRQ ? ex(1, 32'h80, 3'd3, 1, 0, 0, 0, 1)
                : ex(0, 32'h10, 3'd2, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s3_irq_hold got=%h exp=%h", obs, e);
        end
        irq_req_i = 1'b0;
        tick();
        stage_IF_ready = 1'b0;
        e = IRQ ? ex(0, 32'h80, 3'd3, 1, 1, 0, 0, 1)
                : ex(0, 32'h10, 3'd2, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s3_irq_ack got=%h exp=%h", obs, e);
        end
        tick();
        tick();
        checks++;
        if (busy_o !== 1'b0 || irq_ack_o !== 1'b0) begin
            failures++;
            $display("FAIL s3_settle busy=%b ack=%b exp 0 0", busy_o, irq_ack_o);
        end
    endtask

    task automatic test_misalign();
        logic [40:0] e;
        jump_req_i  = 1'b1;
        target_pc_i = 32'h0000_0103;
        tick();
        jump_req_i = 1'b0;
        e = ex(1, 32'h100, 3'd2, 0, 0, 0, 1, 1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s4_misalign got=%h exp=%h", obs, e);
        end
        tick();
        e = ex(1, 32'h100, 3'd2, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s4_pulse_once got=%h exp=%h", obs, e);
        end
        stage_IF_ready = 1'b1;
        tick();
        stage_IF_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        logic [40:0] e;
        jump_req_i     = 1'b1;
        target_pc_i    = 32'h0000_0020;
        stage_IF_ready = 1'b1;
        tick();
        jump_req_i = 1'b0;
        tick();
        #2;
        reset_i = 1'b0;
        #1;
        e = ex(0, 32'h0, 3'd0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s5_async got=%h exp=%h", obs, e);
        end
        stage_IF_ready = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();
        jump_req_i  = 1'b1;
        target_pc_i = 32'h0000_0400;
        tick();
        jump_req_i = 1'b0;
        e = ex(1, 32'h400, 3'd2, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s5_after got=%h exp=%h", obs, e);
        end
        stage_IF_ready = 1'b1;
        tick();
        stage_IF_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_enable_freeze();
        logic [40:0] e;
        jump_req_i  = 1'b1;
        target_pc_i = 32'h0000_0500;
        tick();
        jump_req_i     = 1'b0;
        enable_design  = 1'b0;
        mret_req_i     = 1'b1;
        mepc_i         = 32'h0000_0601;
        stage_IF_ready = 1'b1;
        e = ex(1, 32'h500, 3'd2, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL s6_frozen%0d got=%h exp=%h", i, obs, e);
            end
        end
        mret_req_i    = 1'b0;
        enable_design = 1'b1;
        #1;
        e = ex(1, 32'h500, 3'd2, 1, 0, 0, 0, 1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s6_reenable got=%h exp=%h", obs, e);
        end
        tick();
        stage_IF_ready = 1'b0;
        e = ex(0, 32'h500, 3'd2, 1, 0, 0, 0, 1);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL s6_xfer got=%h exp=%h", obs, e);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_jump_flush();
        test_preempt_mret();
        test_irq_after_flush();
        test_misalign();
        test_async_reset();
        test_enable_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, SHALL set the bubble cycles after each accepted redirect; legal range 0..7.
REQ-002 Parameter RESET_SRC, default 3'd0 (NONE), SHALL be the value of redirect_src_o at reset.
REQ-003 Ports SHALL be exactly:
- clk_i  in  1  sole clock, rising edge.
- reset_i  in  1  reset, asynchronous, active-low.
- enable_design  in  1  global run enable.
- stage_IF_ready  in  1  fetch stage accepts a redirect this cycle.
- jump_req_i  in  1  jump resolved.
- branch_req_i  in  1  taken branch resolved.
- target_pc_i  in  32  jump/branch target.
- mret_req_i  in  1  mret retiring.
- mepc_i  in  32  mret return address.
- irq_req_i  in  1  interrupt pending, level.
- interrupt_vector_i  in  32  trap vector.
- redirect_valid_o  out  1  redirect offered to PC/IF.
- redirect_pc_o  out  32  redirect address.
- redirect_src_o  out  3  source: 0 NONE, 1 BRANCH, 2 JUMP, 3 IRQ, 4 MRET.
- flush_o  out  1  squash younger pipeline stages.
- irq_ack_o  out  1  one-cycle pulse, IRQ redirect accepted.
- mret_ack_o  out  1  one-cycle pulse, MRET redirect accepted.
- misalign_o  out  1  one-cycle pulse, latched target had bits[1:0] != 0.
- busy_o  out  1  state != IDLE.

Function
REQ-004 Priority SHALL be MRET > IRQ > JUMP > BRANCH; jump and branch both use target_pc_i.
REQ-005 The FSM SHALL have exactly three states: IDLE, HOLD and FLUSH.
REQ-006 In IDLE with enable_design=1 and any request, the winner's address and source SHALL be registered and the state SHALL become HOLD; redirect_valid_o SHALL rise the next cycle (1-cycle latency).
REQ-007 redirect_pc_o bits[1:0] SHALL be forced to 0; misalign_o SHALL pulse in the cycle the misaligned address is latched.
REQ-008 In HOLD, redirect_valid_o=1; redirect_pc_o and redirect_src_o SHALL stay stable until accepted, except on preemption (REQ-009).
REQ-009 In HOLD, a strictly higher-priority request SHALL replace the latched redirect in the same edge; equal or lower-priority requests SHALL be dropped.
REQ-010 In HOLD, stage_IF_ready=1 SHALL be the transfer; on the next edge the state SHALL become FLUSH with the counter loaded to FLUSH_CYCLES, or IDLE when FLUSH_CYCLES=0.
REQ-011 If stage_IF_ready=1 and a higher-priority request arrive together in HOLD, the transfer SHALL win and the new request SHALL be handled per the FLUSH/IDLE rules.
REQ-012 irq_ack_o / mret_ack_o SHALL pulse in the cycle following a transfer of source IRQ / MRET.
REQ-013 flush_o SHALL be 1 in the transfer cycle and in every FLUSH cycle.
REQ-014 In FLUSH the counter SHALL decrement each enabled cycle; the state SHALL return to IDLE when it reaches 0 (the FLUSH_CYCLES count, not an extra cycle).
REQ-015 In FLUSH, jump, branch and mret requests SHALL be ignored (wrong-path); irq_req_i, being level, SHALL be taken from IDLE afterwards.
REQ-016 With enable_design=0, state, counter and all registered outputs SHALL hold; ack and misalign pulses SHALL be 0.
REQ-017 The counter width SHALL be 3 bits; it SHALL never underflow.

Reset
REQ-018 reset_i low SHALL asynchronously force the following, including mid-HOLD or mid-FLUSH:
- state IDLE, counter 0;
- redirect_valid_o=0, redirect_pc_o=0, redirect_src_o=RESET_SRC;
- flush_o=0, irq_ack_o=0, mret_ack_o=0, misalign_o=0, busy_o=0.
Release SHALL be synchronous to clk_i.

Configuration
REQ-019 With macro PC_CTRL_IRQ_EN defined, IRQ arbitration and irq_ack_o SHALL operate per REQ-004..015.
REQ-020 Without PC_CTRL_IRQ_EN, irq_req_i and interrupt_vector_i SHALL be ignored, irq_ack_o tied 0, and source IRQ never produced.

Structure
REQ-021 Package pc_ctrl_pkg SHALL hold the state enum, the 3-bit source encoding and the priority ranking function.
REQ-022 Combinational winner selection SHALL live in sub-module pc_redirect_prio (requests in; source and address out).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Scenario 1: jump_req_i=1, target 0x0000_0100, stage_IF_ready=1 -> next cycle redirect_valid_o=1, pc 0x100, src 2; then flush_o high 1+2 cycles; busy_o low after FLUSH.
- Scenario 2: branch in IDLE, stage_IF_ready=0; then mret_req_i with mepc 0x0000_0200 in HOLD -> pc becomes 0x200, src 4; on accept, mret_ack_o pulses once.
- Scenario 3: irq_req_i held high during FLUSH with vector 0x0000_0080 -> no redirect until IDLE, then pc 0x80, src 3, irq_ack_o pulse; built without PC_CTRL_IRQ_EN -> never taken.
- Scenario 4: target 0x0000_0103 -> redirect_pc_o 0x100, misalign_o single pulse.
- Scenario 5: reset_i low mid-FLUSH -> all outputs to reset values immediately, without waiting for a clock edge; after release, a jump is handled normally.
- Scenario 6: enable_design=0 in HOLD for 5 cycles -> all outputs frozen; re-enable with stage_IF_ready=1 -> transfer.
